// File: rtl/hvgen_param_if.sv
// Raster timing bundle: game-core pixel/adjust inputs, position, sync and video outputs.
interface hvgen_param_if #(
    parameter int CW    = 9,
    parameter int RGB_W = 12,
    parameter int ADJ_W = 4
);
    logic                    PCE;
    logic signed [ADJ_W-1:0] H_ADJ;
    logic signed [ADJ_W-1:0] V_ADJ;
    logic [RGB_W-1:0]        iRGB;
    logic [CW-1:0]           HPOS;
    logic [CW-1:0]           VPOS;
    logic                    HBLK;
    logic                    VBLK;
    logic                    HSYN;
    logic                    VSYN;
    logic                    LSTART;
    logic                    FSTART;
    logic [7:0]              FCNT;
    logic [RGB_W-1:0]        oRGB;
    logic                    DE;

    modport master (
        input  PCE, H_ADJ, V_ADJ, iRGB,
        output HPOS, VPOS, HBLK, VBLK, HSYN, VSYN,
        output LSTART, FSTART, FCNT, oRGB, DE
    );

    modport slave (
        output PCE, H_ADJ, V_ADJ, iRGB,
        input  HPOS, VPOS, HBLK, VBLK, HSYN, VSYN,
        input  LSTART, FSTART, FCNT, oRGB, DE
    );
endinterface

// File: rtl/hvgen_param.sv
// Parametrised raster timing generator, single MCLK domain gated by PCE.
// Sync start is frame-latched from the signed adjust inputs.
module hvgen_param #(
    parameter int CW       = 9,
    parameter int H_ACTIVE = 288,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 40,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 12,
    parameter int V_SYNC   = 8,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RGB_W    = 12,
    parameter int ADJ_W    = 4
) (
    input  logic          MCLK,
    input  logic          RESET_N,
    hvgen_param_if.master vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_WRAP  = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_WRAP  = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    if (H_TOTAL > (1 << CW)) begin : g_h_range
        $error("hvgen_param: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (1 << CW)) begin : g_v_range
        $error("hvgen_param: V_TOTAL does not fit in CW bits");
    end

    // Porch tail is shown as negative positions counting up to 2^CW-1.
    function automatic logic [CW-1:0] map_pos(
        input logic [CW-1:0] c,
        input int            wrap,
        input int            total
    );
        int v;
        v = int'(c);
        if (v >= wrap) v = v - total + (1 << CW);
        return v[CW-1:0];
    endfunction

    function automatic logic sync_on(
        input logic [CW-1:0]          c,
        input logic signed [ADJ_W-1:0] adj,
        input int                     nom,
        input int                     lo,
        input int                     hi,
        input int                     width
    );
        int s;
        s = nom + int'(adj);
        if (s < lo) s = lo;
        else if (s > hi) s = hi;
        return (int'(c) >= s) && (int'(c) < s + width);
    endfunction

    logic [CW-1:0]           hc_q, hc_d;
    logic [CW-1:0]           vc_q, vc_d;
    logic signed [ADJ_W-1:0] hadj_q, hadj_d;
    logic signed [ADJ_W-1:0] vadj_q, vadj_d;
    logic                    fs_d;

    logic [CW-1:0]    hpos_q, vpos_q;
    logic             hblk_q, vblk_q;
    logic             hsyn_q, vsyn_q;
    logic             lstart_q, fstart_q;
    logic [7:0]       fcnt_q;
    logic [RGB_W-1:0] orgb_q;
    logic             de_q;

    always_comb begin
        hc_d = (hc_q == H_LAST) ? '0 : hc_q + C_ONE;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + C_ONE;
        end
        fs_d   = (hc_d == '0) && (vc_d == '0);
        hadj_d = fs_d ? vif.H_ADJ : hadj_q;
        vadj_d = fs_d ? vif.V_ADJ : vadj_q;
    end

    // Outputs decode the next count so they line up with HPOS/VPOS.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hc_q     <= H_LAST;
            vc_q     <= V_LAST;
            hadj_q   <= '0;
            vadj_q   <= '0;
            hpos_q   <= '1;
            vpos_q   <= '1;
            hblk_q   <= 1'b1;
            vblk_q   <= 1'b1;
            hsyn_q   <= ~HS_POL;
            vsyn_q   <= ~VS_POL;
            lstart_q <= 1'b0;
            fstart_q <= 1'b0;
            fcnt_q   <= '0;
            orgb_q   <= '0;
            de_q     <= 1'b0;
        end else if (vif.PCE) begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            hadj_q   <= hadj_d;
            vadj_q   <= vadj_d;
            hpos_q   <= map_pos(hc_d, H_WRAP, H_TOTAL);
            vpos_q   <= map_pos(vc_d, V_WRAP, V_TOTAL);
            hblk_q   <= int'(hc_d) >= H_ACTIVE;
            vblk_q   <= int'(vc_d) >= V_ACTIVE;
            hsyn_q   <= sync_on(hc_d, hadj_d, H_ACTIVE + H_FP,
                                H_ACTIVE, H_TOTAL - H_SYNC, H_SYNC)
                        ? HS_POL : ~HS_POL;
            vsyn_q   <= sync_on(vc_d, vadj_d, V_ACTIVE + V_FP,
                                V_ACTIVE, V_TOTAL - V_SYNC, V_SYNC)
                        ? VS_POL : ~VS_POL;
            lstart_q <= (hc_d == '0);
            fstart_q <= fs_d;
            if (fs_d) fcnt_q <= fcnt_q + 8'd1;
            orgb_q   <= (hblk_q | vblk_q) ? '0 : vif.iRGB;
            de_q     <= ~(hblk_q | vblk_q);
        end
    end

    assign vif.HPOS   = hpos_q;
    assign vif.VPOS   = vpos_q;
    assign vif.HBLK   = hblk_q;
    assign vif.VBLK   = vblk_q;
    assign vif.HSYN   = hsyn_q;
    assign vif.VSYN   = vsyn_q;
    assign vif.LSTART = lstart_q;
    assign vif.FSTART = fstart_q;
    assign vif.FCNT   = fcnt_q;
    assign vif.oRGB   = orgb_q;
    assign vif.DE     = de_q;

endmodule

// File: doc/hvgen_param.md
# hvgen_param

Parametrised raster timing generator for the arcade cores. It replaces the fixed-count pixel-clocked generator with a single-clock design gated by a pixel clock-enable. All porch, sync and active widths are parameters. Position outputs use Namco-style wrap-around numbering. It adds frame-latched sync-centering adjust, line/frame strobes, a frame counter and a DE aligned to the blanked RGB output. It sits between the game core (HPOS/VPOS/pixel in) and the video rotate/scaler path.

## Interface
- CW, 9, width of HPOS/VPOS and internal counters
- H_ACTIVE, 288, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 32, horizontal sync width
- H_BP, 40, horizontal back porch
- V_ACTIVE, 224, visible lines
- V_FP, 12, vertical front porch (lines)
- V_SYNC, 8, vertical sync width
- V_BP, 20, vertical back porch
- HS_POL, 0, HSYN active level (0 = active-low)
- VS_POL, 0, VSYN active level
- RGB_W, 12, pixel width
- ADJ_W, 4, width of signed adjust inputs
- MCLK  in  1  system clock; the only clock
- RESET_N  in  1  asynchronous, active-low reset
- PCE  in  1  pixel clock-enable; all state advances only on MCLK edges with PCE=1
- H_ADJ  in  ADJ_W  signed horizontal sync offset (pixels)
- V_ADJ  in  ADJ_W  signed vertical sync offset (lines)
- iRGB  in  RGB_W  pixel from core for current HPOS/VPOS
- HPOS  out  CW  mapped horizontal position
- VPOS  out  CW  mapped vertical position
- HBLK, VBLK  out  1  blanking, aligned with HPOS/VPOS
- HSYN, VSYN  out  1  sync at HS_POL/VS_POL level, aligned with HPOS/VPOS
- LSTART  out  1  one-PCE strobe at hc=0
- FSTART  out  1  one-PCE strobe at hc=0, vc=0
- FCNT  out  8  frame counter
- oRGB  out  RGB_W  registered iRGB, zero when blanked; one pixel behind HPOS
- DE  out  1  ~(HBLK|VBLK) delayed one PCE; aligned with oRGB

## Operation
- H_TOTAL = sum of H params; V_TOTAL = sum of V params.
- Elaboration error if H_TOTAL or V_TOTAL > 2^CW.
- Counters: hc in 0..H_TOTAL-1, vc in 0..V_TOTAL-1.
- hc wraps to 0 after H_TOTAL-1; vc increments on that wrap and itself wraps after V_TOTAL-1.
- Position mapping: HPOS = hc if hc < H_ACTIVE+H_FP+H_SYNC, else (hc − H_TOTAL) mod 2^CW. This yields ascending values into the top of the range, reaching 2^CW−1 just before 0. VPOS is mapped the same way from vc.
- HBLK = (hc ≥ H_ACTIVE); VBLK = (vc ≥ V_ACTIVE).
- Horizontal sync start: HSS = clamp(H_ACTIVE+H_FP+hadj, H_ACTIVE, H_TOTAL−H_SYNC). HSYN is active for HSS ≤ hc < HSS+H_SYNC.
- Vertical sync start: VSS = clamp(V_ACTIVE+V_FP+vadj, V_ACTIVE, V_TOTAL−V_SYNC). VSYN is active for VSS ≤ vc < VSS+V_SYNC and changes only at hc=0.
- hadj/vadj are internal copies of H_ADJ/V_ADJ, latched on the PCE that enters hc=0, vc=0. Changes take effect from the next frame, so there is no mid-frame tearing.
- FCNT increments on every FSTART and wraps 255→0.
- oRGB samples iRGB on each PCE: 0 if HBLK|VBLK in that cycle, else iRGB.

## Timing
- Reset (async assert, any time, including mid-frame):
  - hc=H_TOTAL−1, vc=V_TOTAL−1, so HPOS=VPOS=2^CW−1.
  - HBLK=VBLK=1, HSYN/VSYN inactive, LSTART=FSTART=0, FCNT=0, oRGB=0, DE=0.
  - hadj=vadj=0.
- First PCE after deassert: hc=0, vc=0, LSTART=FSTART=1, FCNT=1, adjusts latched.
- Outputs are registers. HBLK/VBLK/HSYN/VSYN/LSTART/FSTART describe the hc/vc currently shown on HPOS/VPOS; next state is decoded, with no extra lag.
- oRGB/DE lag HPOS by exactly one PCE.
- PCE=0 holds every output and internal state. PCE=1 every MCLK is legal.
- LSTART/FSTART are held high for the whole PCE period in which they are asserted (not one MCLK).

## Test plan
- Reset then free-run PCE=1, defaults:
  - HPOS runs 0..343, then 472..511, then 0.
  - HSYN low for HPOS 312..343; HBLK high from HPOS 288.
  - FSTART every 101376 PCE.
- Vertical, defaults:
  - VPOS runs 0..243, then 492..511, then 0.
  - VSYN low for lines 236..243, edges coincident with LSTART; VBLK from line 224.
- Adjust latching:
  - H_ADJ=+3 written mid-frame: current frame keeps HSYN 312..343; after the next FSTART, HSYN spans 315..346.
  - H_ADJ=−8 gives 304..335.
  - Instance with H_FP=4 and H_ADJ=−8: HSS clamps to 288.
- PCE gating: PCE toggling 1-of-4 → every output changes only on PCE cycles; counts identical to the PCE=1 run.
- RGB/DE alignment:
  - iRGB = {HPOS[3:0]×3}: oRGB equals the previous-pixel value when DE=1, and 0 for the first pixel after HBLK rises.
  - DE falls one PCE after HBLK rises.
- Reset mid-frame at vc=100: outputs return to reset values immediately. FCNT=1 on the first PCE after deassert, and the 255→0 wrap is checked over 256 frames.
